// File: rtl/lut_ram_ctrl_pkg.sv
// lut_ram_ctrl_pkg: shared types and helpers for the lut_ram write controller
// Contents:
//   ctrl_state_t - controller state (INIT sweep / RUN arbitration)
//   wr_req_t     - write request {addr, data} at the default RAM geometry
//   addr_bits()  - address width for a depth, at least 1 bit
package lut_ram_ctrl_pkg;

    typedef enum logic {INIT, RUN} ctrl_state_t;

    localparam int REQ_WIDTH = 32;
    localparam int REQ_DEPTH = 32;
    localparam int REQ_AW    = $clog2(REQ_DEPTH);

    typedef struct packed {
        logic [REQ_AW-1:0]    addr;
        logic [REQ_WIDTH-1:0] data;
    } wr_req_t;

    function automatic int addr_bits(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/lut_ram_write_arb.sv
// lut_ram_write_arb: N-way one-hot arbiter, search starts just after i_last
// Ports:
//   i_req   - request vector
//   i_last  - index granted last; tie to N-1 for lowest-index-first priority
//   o_grant - one-hot grant (all zero when no request)
module lut_ram_write_arb #(
    parameter int N = 2,
    localparam int PW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_last,
    output logic [N-1:0]  o_grant
);

    logic [PW-1:0] w_idx;

    // Walk from the farthest candidate back to the nearest so the nearest
    // requester after i_last is the last assignment and therefore wins.
    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = PW'((int'(i_last) + k) % N);
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lut_ram_write_ctrl.sv
// lut_ram_write_ctrl: init sweep plus arbitrated, one-deep registered write port for lut_ram
// Optional build macro: LUT_RAM_WRITE_CTRL_RR_EN selects round-robin arbitration
// (fixed priority, lowest index first, when undefined).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   init_req            - pulse requesting a re-initialisation sweep
//   init_done           - sweep complete, client writes accepted
//   wr_valid/addr/data  - per-client write requests
//   wr_ready            - per-client accept (combinational, at most one high)
//   ram_write/waddr/wdata - lut_ram write port
//   pend_valid/addr     - client write currently on the RAM port, for read forwarding
module lut_ram_write_ctrl
    import lut_ram_ctrl_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 32,
    parameter int NUM_WRITERS = 2,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    localparam int AW = addr_bits(DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  init_req,
    output logic                                  init_done,
    input  logic [NUM_WRITERS-1:0]                wr_valid,
    input  logic [NUM_WRITERS-1:0][AW-1:0]        wr_addr,
    input  logic [NUM_WRITERS-1:0][WIDTH-1:0]     wr_data,
    output logic [NUM_WRITERS-1:0]                wr_ready,
    output logic                                  ram_write,
    output logic [AW-1:0]                         ram_waddr,
    output logic [WIDTH-1:0]                      ram_wdata,
    output logic                                  pend_valid,
    output logic [AW-1:0]                         pend_addr
);

    localparam int PW = NUM_WRITERS > 1 ? $clog2(NUM_WRITERS) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } stage_req_t;

    ctrl_state_t r_state;
    logic [AW-1:0] r_cnt, r_waddr, w_next_cnt;
    logic [WIDTH-1:0] r_wdata;
    logic r_write, r_done, r_pend, w_accept;
    logic [NUM_WRITERS-1:0] w_grant, w_ready;
    logic [PW-1:0] w_last;
    stage_req_t w_req;

    lut_ram_write_arb #(.N(NUM_WRITERS)) u_arb (
        .i_req   (wr_valid),
        .i_last  (w_last),
        .o_grant (w_grant)
    );

    // init_done is only high in RUN, so it doubles as the accept enable.
    assign w_ready  = (r_done && !init_req) ? w_grant : '0;
    assign w_accept = |w_ready;

    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_WRITERS; i++)
            if (w_grant[i]) w_req = '{addr: wr_addr[i], data: wr_data[i]};
    end

`ifdef LUT_RAM_WRITE_CTRL_RR_EN
    logic [PW-1:0] r_last, w_gidx;

    always_comb begin
        w_gidx = r_last;
        for (int i = 0; i < NUM_WRITERS; i++)
            if (w_grant[i]) w_gidx = PW'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last <= '0;
        else if (w_accept)
            r_last <= w_gidx;
    end

    assign w_last = r_last;
`else
    assign w_last = PW'(NUM_WRITERS - 1);
`endif

    // r_write low in INIT means the sweep has not emitted address 0 yet.
    assign w_next_cnt = r_write ? r_cnt + 1'b1 : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_pend  <= 1'b0;
        end else if (r_state == INIT) begin
            if (r_write && r_cnt == LAST) begin
                r_state <= RUN;
                r_done  <= 1'b1;
                r_write <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_write <= 1'b1;
                r_waddr <= w_next_cnt;
                r_wdata <= INIT_VALUE;
                r_cnt   <= w_next_cnt;
            end
        end else if (init_req) begin
            // Any client write on the port this cycle completes at this edge,
            // so the sweep can put address 0 on the port immediately.
            r_state <= INIT;
            r_done  <= 1'b0;
            r_pend  <= 1'b0;
            r_write <= 1'b1;
            r_cnt   <= '0;
            r_waddr <= '0;
            r_wdata <= INIT_VALUE;
        end else begin
            r_write <= w_accept;
            r_pend  <= w_accept;
            if (w_accept) begin
                r_waddr <= w_req.addr;
                r_wdata <= w_req.data;
            end
        end
    end

    assign init_done  = r_done;
    assign wr_ready   = w_ready;
    assign ram_write  = r_write;
    assign ram_waddr  = r_waddr;
    assign ram_wdata  = r_wdata;
    assign pend_valid = r_pend;
    assign pend_addr  = r_waddr;

endmodule
